// File: rtl/aes_key_schedule_seq_pkg.sv
// aes_key_schedule_seq_pkg: key-length encoding, FSM states and AES byte helpers for the key schedule.
package aes_key_schedule_seq_pkg;
  typedef enum logic [1:0] {KL_128, KL_192, KL_256, KL_BAD} key_len_t;
  typedef enum logic {IDLE, EXPAND} state_t;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [3:0] nk_of(key_len_t kl);
    return kl == KL_256 ? 4'd8 : kl == KL_192 ? 4'd6 : 4'd4;
  endfunction
  function automatic logic [3:0] nr_of(key_len_t kl);
    return nk_of(kl) + 4'd6;
  endfunction
  function automatic logic [7:0] sbox(logic [7:0] x);
    return SBOX[x];
  endfunction
  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// aes_key_schedule_seq_if: job request, status and round-key read port of the key schedule.
// AES_KS_REVERSE_READ_EN adds rk_rev for decryption-order reads.
interface aes_key_schedule_seq_if #(
  parameter int MAX_KEY_BITS = 256,
  parameter int RK_IDX_W = 4
);
  logic start;
  logic [1:0] key_len;
  logic [MAX_KEY_BITS-1:0] key_in;
  logic ready;
  logic busy;
  logic done;
  logic err;
  logic [3:0] nr;
  logic [RK_IDX_W:0] rk_avail;
  logic [RK_IDX_W-1:0] rk_idx;
  logic [127:0] rk_out;
`ifdef AES_KS_REVERSE_READ_EN
  logic rk_rev;
  modport master (
    output start, key_len, key_in, rk_idx, rk_rev,
    input ready, busy, done, err, nr, rk_avail, rk_out
  );
  modport slave (
    input start, key_len, key_in, rk_idx, rk_rev,
    output ready, busy, done, err, nr, rk_avail, rk_out
  );
`else
  modport master (
    output start, key_len, key_in, rk_idx,
    input ready, busy, done, err, nr, rk_avail, rk_out
  );
  modport slave (
    input start, key_len, key_in, rk_idx,
    output ready, busy, done, err, nr, rk_avail, rk_out
  );
`endif
endinterface

// File: rtl/aes_key_schedule_seq_sbox_word.sv
// aes_key_schedule_seq_sbox_word: SubWord, four parallel AES S-box lookups.
module aes_key_schedule_seq_sbox_word
  import aes_key_schedule_seq_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);
  assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
endmodule

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: sequential AES-128/192/256 key expansion, one word per clock, round keys read by index.
// AES_KS_REVERSE_READ_EN adds rk_rev, mapping rk_idx to nr-rk_idx.
module aes_key_schedule_seq
  import aes_key_schedule_seq_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter int RK_IDX_W = 4
) (
  input logic clk,
  input logic rst_n,
  aes_key_schedule_seq_if.slave bus
);
  localparam int NK_MAX = MAX_KEY_BITS / 32;
  localparam int NW = 4 * (NK_MAX + 7);
  localparam int WW = $clog2(NW);
  localparam int AW = RK_IDX_W + 1;
  state_t state, state_nxt;
  logic [31:0] w [NW];
  logic [WW-1:0] i;
  logic [2:0] m;
  logic [7:0] rcon;
  key_len_t klen, kl_in;
  logic [3:0] nk, nr_q;
  logic [AW-1:0] avail;
  logic legal, go, last;
  logic [31:0] t, sub_in, sub, nw;
  logic [RK_IDX_W-1:0] ridx;
  assign kl_in = key_len_t'(bus.key_len);
  assign legal = kl_in != KL_BAD && 32 * int'(nk_of(kl_in)) <= MAX_KEY_BITS;
  assign go = bus.start && legal;
  assign nk = nk_of(klen);
  assign last = i == WW'(4 * int'(nr_q) + 3);
  assign t = w[i - WW'(1)];
  // one S-box word serves both the rcon step (rotated) and the 256-bit mid-block step
  assign sub_in = m == 3'd0 ? {t[23:0], t[31:24]} : t;
  aes_key_schedule_seq_sbox_word u_sbox (.word(sub_in), .sub(sub));
  assign nw = w[i - WW'(nk)] ^ (m == 3'd0 ? sub ^ {rcon, 24'h0} : (nk == 4'd8 && m == 3'd4) ? sub : t);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb state_nxt = state == IDLE ? (go ? EXPAND : IDLE) : (last ? IDLE : EXPAND);
  always_comb begin
    bus.ready = state == IDLE;
    bus.busy = state == EXPAND;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
      i <= '0;
      m <= '0;
      rcon <= 8'h01;
      klen <= KL_128;
      nr_q <= '0;
      avail <= '0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.done <= state == EXPAND && last;
      bus.err <= bus.start && state == IDLE && !legal;
      if (state == IDLE && go) begin
        for (int k = 0; k < NK_MAX; k++)
          if (k < int'(nk_of(kl_in))) w[k] <= bus.key_in[MAX_KEY_BITS-1-32*k -: 32];
        i <= WW'(nk_of(kl_in));
        m <= '0;
        rcon <= 8'h01;
        klen <= kl_in;
        nr_q <= nr_of(kl_in);
        avail <= AW'(nk_of(kl_in) >> 2);
      end else if (state == EXPAND) begin
        w[i] <= nw;
        i <= i + WW'(1);
        m <= m == 3'(nk - 4'd1) ? 3'd0 : m + 3'd1;
        if (m == 3'd0) rcon <= xtime(rcon);
        if (i[1:0] == 2'b11) avail <= avail + AW'(1);
      end
    end
  end
  assign bus.nr = nr_q;
  assign bus.rk_avail = avail;
  always_comb begin
`ifdef AES_KS_REVERSE_READ_EN
    ridx = bus.rk_rev ? RK_IDX_W'(nr_q) - bus.rk_idx : bus.rk_idx;
`else
    ridx = bus.rk_idx;
`endif
    bus.rk_out = '0;
    for (int k = 0; k < 4; k++)
      bus.rk_out[127-32*k -: 32] = (4 * int'(ridx) + k < NW) ? w[WW'(4 * int'(ridx) + k)] : 32'h0;
  end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb_aes_key_schedule_seq: FIPS-197 vectors, random keys against a FIPS-style reference expansion, corner sequences.
module tb_aes_key_schedule_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  aes_key_schedule_seq_if #(.MAX_KEY_BITS(256), .RK_IDX_W(4)) bus();
  aes_key_schedule_seq #(.MAX_KEY_BITS(256), .RK_IDX_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [1:0] kl;
    logic [255:0] key;
    logic [3:0] idx;
    logic [127:0] rk;
  } vec_t;
  vec_t vt[3];
  int checks = 0;
  int failures = 0;
  logic [7:0] sbt[256];
  logic [31:0] mw[60];
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
  endfunction
  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] r = 8'h01;
    for (int k = 1; k < n; k++) r = gmul(r, 8'h02);
    return r;
  endfunction
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask
  task automatic expand_model(input logic [255:0] key, input int nk);
    logic [31:0] t;
    for (int j = 0; j < 60; j++) mw[j] = 32'h0;
    for (int j = 0; j < nk; j++) mw[j] = key[255-32*j -: 32];
    for (int j = nk; j < 4 * (nk + 7); j++) begin
      t = mw[j-1];
      if (j % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_of(j / nk), 24'h0};
      else if (nk > 6 && j % nk == 4) t = subw(t);
      mw[j] = mw[j-nk] ^ t;
    end
  endtask
  function automatic logic [127:0] mrk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction
  task automatic start_job(input logic [1:0] kl, input logic [255:0] key);
    @(negedge clk);
    bus.start = 1'b1;
    bus.key_len = kl;
    bus.key_in = key;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  // runs one job, tracking rk_avail and early round keys every cycle; optional start pulse while busy
  task automatic run_job(input logic [1:0] kl, input logic [255:0] key, input logic collide, input string tag);
    int nk, av, lat, bad_av, bad_rk, bad_err, bad_all;
    nk = 4 + 2 * int'(kl);
    bad_av = 0; bad_rk = 0; bad_err = 0; bad_all = 0;
    expand_model(key, nk);
    start_job(kl, key);
    for (lat = 0; lat < 200; lat++) begin
      if (lat > 0) @(negedge clk);
      bus.start = collide && lat == 5;
      if (collide && lat == 5) begin
        bus.key_len = 2'd2;
        bus.key_in = ~key;
      end
      av = (nk + lat) / 4;
      if (int'(bus.rk_avail) != av) bad_av++;
      if (bus.err) bad_err++;
      bus.rk_idx = 4'(av - 1);
      #1;
      if (bus.rk_out !== mrk(av - 1)) bad_rk++;
      if (bus.done) break;
    end
    check({tag, "_latency"}, 256'(lat), 256'(4 * (nk + 7) - nk));
    check({tag, "_nr"}, 256'(bus.nr), 256'(nk + 6));
    check({tag, "_avail_track"}, 256'(bad_av), 256'(0));
    check({tag, "_early_rk"}, 256'(bad_rk), 256'(0));
    check({tag, "_no_err"}, 256'(bad_err), 256'(0));
    @(negedge clk);
    check({tag, "_done_pulse"}, 256'({bus.done, bus.busy, bus.ready}), 256'(3'b001));
    for (int r = 0; r <= nk + 6; r++) begin
      @(negedge clk);
      bus.rk_idx = 4'(r);
      #1;
      if (bus.rk_out !== mrk(r)) bad_all++;
    end
    check({tag, "_all_rk"}, 256'(bad_all), 256'(0));
  endtask
  initial begin
    int lat, dn;
    logic [255:0] rkey;
    logic [1:0] rkl;
    bus.start = 1'b0;
    bus.key_len = 2'd0;
    bus.key_in = '0;
    bus.rk_idx = '0;
`ifdef AES_KS_REVERSE_READ_EN
    bus.rk_rev = 1'b0;
`endif
    rst_n = 1'b0;
    vt[0] = '{kl: 2'd0, key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, idx: 4'd10,
              rk: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[1] = '{kl: 2'd1, key: {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, idx: 4'd12,
              rk: 128'he98ba06f448c773c8ecc720401002202};
    vt[2] = '{kl: 2'd2, key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, idx: 4'd14,
              rk: 128'hfe4890d1e6188d0b046df344706c631e};
    build_sbox();
    repeat (3) @(negedge clk);
    #1;
    check("rst_flags", 256'({bus.ready, bus.busy, bus.done, bus.err}), 256'(4'b1000));
    check("rst_nr", 256'(bus.nr), 256'(0));
    check("rst_avail", 256'(bus.rk_avail), 256'(0));
    check("rst_rk0", 256'(bus.rk_out), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 3; v++) begin
      run_job(vt[v].kl, vt[v].key, 1'b0, $sformatf("vec%0d", v));
      bus.rk_idx = vt[v].idx;
      #1;
      check($sformatf("vec%0d_fips", v), 256'(bus.rk_out), 256'(vt[v].rk));
    end
    for (int n = 0; n < 6; n++) begin
      rkl = 2'($urandom_range(0, 2));
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(rkl, rkey, 1'b0, $sformatf("rnd%0d", n));
    end
    run_job(vt[0].kl, vt[0].key, 1'b0, "a1_again");
    @(negedge clk);
    bus.start = 1'b1;
    bus.key_len = 2'd3;
    bus.key_in = ~vt[0].key;
    @(negedge clk);
    bus.start = 1'b0;
    check("bad_err_pulse", 256'({bus.err, bus.ready, bus.busy}), 256'(3'b110));
    check("bad_keeps_avail", 256'(bus.rk_avail), 256'(11));
    check("bad_keeps_nr", 256'(bus.nr), 256'(10));
    bus.rk_idx = 4'd10;
    #1;
    check("bad_keeps_rk", 256'(bus.rk_out), 256'(vt[0].rk));
    @(negedge clk);
    check("bad_err_one_cycle", 256'(bus.err), 256'(0));
    run_job(vt[0].kl, vt[0].key, 1'b1, "collide");
    bus.rk_idx = 4'd10;
    #1;
    check("collide_fips", 256'(bus.rk_out), 256'(vt[0].rk));
    start_job(vt[1].kl, vt[1].key);
    for (int n = 0; n < 200 && !bus.done; n++) @(negedge clk);
    check("b2b_first_done", 256'(bus.done), 256'(1));
    bus.start = 1'b1;
    bus.key_len = vt[0].kl;
    bus.key_in = vt[0].key;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_accepted", 256'({bus.busy, bus.done}), 256'(2'b10));
    check("b2b_nr", 256'(bus.nr), 256'(10));
    check("b2b_avail", 256'(bus.rk_avail), 256'(1));
    for (lat = 0; lat < 200; lat++) begin
      if (lat > 0) @(negedge clk);
      if (bus.done) break;
    end
    check("b2b_latency", 256'(lat), 256'(40));
    bus.rk_idx = 4'd10;
    #1;
    check("b2b_fips", 256'(bus.rk_out), 256'(vt[0].rk));
    start_job(vt[2].kl, vt[2].key);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    bus.rk_idx = 4'd0;
    #1;
    check("midrst_flags", 256'({bus.ready, bus.busy, bus.done, bus.err}), 256'(4'b1000));
    check("midrst_nr_avail", 256'({bus.nr, bus.rk_avail}), 256'(0));
    check("midrst_rk0", 256'(bus.rk_out), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    check("midrst_no_done", 256'(dn), 256'(0));
    run_job(vt[0].kl, vt[0].key, 1'b0, "post_rst");
    bus.rk_idx = 4'd10;
    #1;
    check("post_rst_fips", 256'(bus.rk_out), 256'(vt[0].rk));
`ifdef AES_KS_REVERSE_READ_EN
    bus.rk_rev = 1'b1;
    bus.rk_idx = 4'd0;
    #1;
    check("rev_idx0", 256'(bus.rk_out), 256'(vt[0].rk));
    bus.rk_idx = 4'd10;
    #1;
    check("rev_idx10", 256'(bus.rk_out), 256'(vt[0].key[255:128]));
    bus.rk_rev = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
